// File: rtl/vga_record_history.sv
// VGA overlay: DEPTH-deep history of BCD records; renders one, frame-latched, 2-stage pixel path.
// Optional: define VGA_RECORD_BLINK_EN to blink older records (sel != 0) with a 64-frame period.
module vga_record_history #(
  parameter int DIGITS     = 8,
  parameter int DEPTH      = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 320,
  parameter int Y0         = 352,
  parameter int HBP        = 144,
  parameter int VBP        = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               hc,
  input  logic [9:0]               vc,
  input  logic                     rec_valid,
  input  logic [4*DIGITS-1:0]      rec_digits,
  input  logic [$clog2(DEPTH)-1:0] sel,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     has_record,
  output logic                     has_num
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = 4 * DIGITS;
  localparam logic [10:0] XLO  = 11'(X0);
  localparam logic [10:0] XHI  = 11'(X0 + DIGITS * (8 << SCALE_LOG2));
  localparam logic [10:0] YLO  = 11'(Y0);
  localparam logic [10:0] YHI  = 11'(Y0 + (16 << SCALE_LOG2));
  localparam logic [10:0] HOFF = 11'(HBP);
  localparam logic [10:0] VOFF = 11'(VBP);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [RW-1:0] ring_q [DEPTH];
  logic [RW-1:0] disp_q, disp_d;
  logic          disp_vld_q, disp_vld_d;
  logic          inside_q, inside_d;
  logic [3:0]    nib_q, nib_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic          has_num_q, has_num_d;

  logic          frame_tick;
  logic [PW-1:0] rd_idx;
  logic [10:0]   x, y, dx, dy;
  logic [DW-1:0] dig;
  logic [RW-1:0] disp_sh;
  logic [7:0]    row_bits;
  logic          blank;

  assign frame_tick = (hc == 10'd0) && (vc == 10'd0);
  assign rd_idx     = wr_ptr_q - PW'(1) - sel;
  assign rec_count  = cnt_q;
  assign has_record = (cnt_q != '0);
  assign has_num    = has_num_q;

`ifdef VGA_RECORD_BLINK_EN
  logic [5:0] blink_q;
  logic       sel_nz_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q  <= '0;
      sel_nz_q <= 1'b0;
    end else if (frame_tick) begin
      blink_q  <= blink_q + 6'd1;
      sel_nz_q <= (sel != '0);
    end
  end
  assign blank = blink_q[5] && sel_nz_q;
`else
  assign blank = 1'b0;
`endif

  // Seven-segment style glyph: segments gfedcba drawn into an 8x16 cell
  function automatic logic [7:0] glyph_row(input logic [3:0] n, input logic [3:0] r);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    glyph_row = 8'h00;
    if (r == 4'd2 && s[0])
      glyph_row = 8'h7E;
    else if (r >= 4'd3 && r <= 4'd7)
      glyph_row = {1'b0, s[5], s[5], 2'b00, s[1], s[1], 1'b0};
    else if (r == 4'd8 && s[6])
      glyph_row = 8'h7E;
    else if (r >= 4'd9 && r <= 4'd13)
      glyph_row = {1'b0, s[4], s[4], 2'b00, s[2], s[2], 1'b0};
    else if (r == 4'd14 && s[3])
      glyph_row = 8'h7E;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (rec_valid) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + (PW + 1)'(1);
    end
  end

  always_comb begin
    disp_d     = disp_q;
    disp_vld_d = disp_vld_q;
    if (frame_tick) begin
      disp_d     = ring_q[rd_idx];
      disp_vld_d = ({1'b0, sel} < cnt_q);
    end
  end

  always_comb begin
    x        = {1'b0, hc} - HOFF;
    y        = {1'b0, vc} - VOFF;
    dx       = x - XLO;
    dy       = y - YLO;
    inside_d = (hc >= 10'(HBP)) && (vc >= 10'(VBP)) &&
               (x >= XLO) && (x < XHI) &&
               (y >= YLO) && (y < YHI) &&
               disp_vld_q && !blank;
    dig      = DW'(dx >> (3 + SCALE_LOG2));
    col_d    = 3'(dx >> SCALE_LOG2);
    row_d    = 4'(dy >> SCALE_LOG2);
    // Digit 0 sits in the top nibble, so shift it up to the MSBs
    disp_sh  = disp_q << {dig, 2'b00};
    nib_d    = disp_sh[RW-1 -: 4];
  end

  always_comb begin
    row_bits  = glyph_row(nib_q, row_q);
    has_num_d = inside_q && row_bits[3'd7 - col_q];
  end

  always_ff @(posedge clk) begin
    if (rec_valid && !clear) ring_q[wr_ptr_q] <= rec_digits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      inside_q   <= 1'b0;
      nib_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      has_num_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      disp_vld_q <= disp_vld_d;
      inside_q   <= inside_d;
      nib_q      <= nib_d;
      row_q      <= row_d;
      col_q      <= col_d;
      has_num_q  <= has_num_d;
    end
  end
endmodule

// File: tb/tb_vga_record_history.sv
// Directed bench for vga_record_history: counter table plus
// region scans against a division-based glyph model.
module tb_vga_record_history;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hc, vc;
  logic        rec_valid;
  logic [31:0] rec_digits;
  logic [1:0]  sel;
  logic        clear;
  logic [2:0]  rec_count;
  logic        has_record;
  logic        has_num;

  vga_record_history dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .rec_valid(rec_valid), .rec_digits(rec_digits),
    .sel(sel), .clear(clear), .rec_count(rec_count),
    .has_record(has_record), .has_num(has_num)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int scan_bad;
  bit expq[$];

  // {top, upper sides, middle, lower sides, bottom} row bytes
  logic [39:0] FONT [10] = '{
    40'h7E6600667E, 40'h0006000600, 40'h7E067E607E, 40'h7E067E067E,
    40'h00667E0600, 40'h7E607E067E, 40'h7E607E667E, 40'h7E06000600,
    40'h7E667E667E, 40'h7E667E067E
  };

  typedef struct {
    logic        wr;
    logic        clr;
    logic [31:0] dig;
    logic [2:0]  cnt;
    logic        hr;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model(int h, int v, logic [31:0] rec, bit vld);
    int x, y, d, col, row, n;
    logic [39:0] f;
    logic [7:0] b;
    x = h - 144;
    y = v - 35;
    if (!vld || h < 144 || v < 35) return 1'b0;
    if (x < 320 || x >= 448 || y < 352 || y >= 384) return 1'b0;
    d   = (x - 320) / 16;
    col = ((x - 320) % 16) / 2;
    row = (y - 352) / 2;
    n   = int'(rec[31 - 4*d -: 4]);
    if (n > 9) return 1'b0;
    f = FONT[n];
    case (row)
      2:             b = f[39:32];
      3, 4, 5, 6, 7: b = f[31:24];
      8:             b = f[23:16];
      9, 10, 11, 12, 13: b = f[15:8];
      14:            b = f[7:0];
      default:       b = 8'h00;
    endcase
    return b[7 - col];
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic step(int h, int v, bit e);
    bit ee;
    hc = 10'(h);
    vc = 10'(v);
    expq.push_back(e);
    tick_clk();
    if (expq.size() == 2) begin
      ee = expq.pop_front();
      if (has_num !== ee) scan_bad++;
    end
  endtask

  task automatic scan(string nm, logic [31:0] rec, bit vld);
    scan_bad = 0;
    expq.delete();
    for (int v = 385; v <= 420; v++)
      for (int h = 462; h <= 593; h++)
        step(h, v, model(h, v, rec, vld));
    step(10, 10, 1'b0);
    step(10, 10, 1'b0);
    chk(nm, scan_bad, 0);
  endtask

  task automatic frame();
    hc = 10'd0;
    vc = 10'd0;
    tick_clk();
    hc = 10'd10;
    vc = 10'd10;
  endtask

  task automatic write(logic [31:0] d);
    rec_valid  = 1'b1;
    rec_digits = d;
    tick_clk();
    rec_valid  = 1'b0;
  endtask

  task automatic probe(string nm, int h, int v, logic e);
    hc = 10'(h);
    vc = 10'(v);
    tick_clk();
    tick_clk();
    chk(nm, has_num, e);
    hc = 10'd10;
    vc = 10'd10;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h11111111, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h22222222, 3'd2, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h33333333, 3'd3, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h44444444, 3'd4, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h55555555, 3'd4, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h00000000, 3'd4, 1'b1};

    rst = 1'b1; hc = 10'd10; vc = 10'd10;
    rec_valid = 1'b0; rec_digits = '0; sel = '0; clear = 1'b0;
    tick_clk();
    tick_clk();
    chk("reset_has_num", has_num, 0);
    chk("reset_count", rec_count, 0);
    chk("reset_has_record", has_record, 0);
    rst = 1'b0;
    tick_clk();

    write(32'h12345678);
    chk("w1_count", rec_count, 1);
    chk("w1_has_record", has_record, 1);
    scan("pre_tick_blank", 32'h12345678, 1'b0);
    frame();
    scan("frame_12345678", 32'h12345678, 1'b1);

    hc = 10'd10; vc = 10'd10;
    tick_clk();
    tick_clk();
    chk("lat_idle", has_num, 0);
    hc = 10'd474; vc = 10'd395;
    tick_clk();
    hc = 10'd10; vc = 10'd10;
    chk("lat_1clk", has_num, 0);
    tick_clk();
    chk("lat_2clk", has_num, 1);
    tick_clk();
    chk("lat_3clk", has_num, 0);

    hc = 10'd474; vc = 10'd395;
    tick_clk();
    tick_clk();
    chk("pre_rst_lit", has_num, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_has_num", has_num, 0);
    chk("rst_async_count", rec_count, 0);
    chk("rst_async_has_record", has_record, 0);
    tick_clk();
    rst = 1'b0;
    scan("post_rst_blank", 32'h12345678, 1'b0);
    frame();
    scan("post_rst_frame_blank", 32'h12345678, 1'b0);

    foreach (tbl[i]) begin
      rec_valid  = tbl[i].wr;
      clear      = tbl[i].clr;
      rec_digits = tbl[i].dig;
      tick_clk();
      rec_valid = 1'b0;
      clear     = 1'b0;
      chk($sformatf("tbl%0d_count", i), rec_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_has_record", i), has_record, tbl[i].hr);
    end
    sel = 2'd0;
    frame();
    scan("sel0_fives", 32'h55555555, 1'b1);
    sel = 2'd3;
    frame();
    scan("sel3_twos", 32'h22222222, 1'b1);

    clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    chk("clear_count", rec_count, 0);
    write(32'hA9012345);
    chk("one_count", rec_count, 1);
    chk("one_has_record", has_record, 1);
    sel = 2'd2;
    frame();
    scan("sel2_invalid_blank", 32'hA9012345, 1'b0);
    sel = 2'd0;
    frame();
    scan("nibble_a_frame", 32'hA9012345, 1'b1);
    probe("nibble_a_cell", 466, 391, 1'b0);
    probe("digit1_nine", 482, 391, 1'b1);

    write(32'h11111111);
    write(32'h22222222);
    write(32'h33333333);
    rec_valid  = 1'b1;
    clear      = 1'b1;
    rec_digits = 32'h44444444;
    tick_clk();
    rec_valid = 1'b0;
    clear     = 1'b0;
    chk("clr_wins_count", rec_count, 0);
    chk("clr_wins_has_record", has_record, 0);
    frame();
    scan("clr_wins_blank", 32'h44444444, 1'b0);

`ifdef VGA_RECORD_BLINK_EN
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    write(32'h88888888);
    write(32'h88888888);
    sel = 2'd1;
    for (int t = 1; t <= 64; t++) begin
      frame();
      if (t == 1 || t == 31 || t == 32 || t == 63 || t == 64)
        probe($sformatf("blink_t%0d", t), 466, 391, (t % 64) < 32);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
